// File: rtl/dma_requester_pkg.sv
// Shared types for the DMA requester: FSM state encoding and transfer direction codes.
// No logic here; imported by the requester top.
package dma_requester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_RELEASE,
    ST_FINISH
  } state_t;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

endpackage

// File: rtl/dma_requester_fifo.sv
// Synchronous byte FIFO (module dma_fifo); zero read latency, head valid whenever empty=0.
// Push while full or pop while empty is dropped; push and pop in one cycle both complete.
module dma_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_vld,
  input  logic [7:0] push_dat,
  input  logic       pop_vld,
  output logic [7:0] head_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_fire;
  logic          pop_fire;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign head_dat = mem[rptr_q];

  always_comb begin
    push_fire = push_vld && !full;
    pop_fire  = pop_vld && !empty;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (push_fire) wptr_d = wptr_q + AW'(1);
    if (pop_fire)  rptr_d = rptr_q + AW'(1);
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push_fire) mem[wptr_q] <= push_dat;
  end

endmodule

// File: rtl/dma_requester.sv
// Single-transfer-mode DMA requester with TX/RX byte FIFOs; bus data driven combinationally in XFER.
// DRQ is held low while the selected FIFO cannot serve a byte; local side uses valid/ready.
module dma_requester
  import dma_requester_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic       dma_request,
  input  logic       dma_acknowledge_n,
  input  logic       io_read_n,
  input  logic       io_write_n,
  input  logic       terminal_count_n,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable,
  input  logic       start,
  input  logic       direction,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       tc_seen,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready
);

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic       tc_flag_q, tc_flag_d;
  logic       tc_seen_q, tc_seen_d;
  logic       busy_q, busy_d;
  logic       aborted_q, aborted_d;
  logic [7:0] wdata_q, wdata_d;

  logic       tx_pop, rx_push;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head;
  logic       can_serve, strobe_n, drq, drive, done_c;

  dma_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (wr_valid),
    .push_dat (wr_data),
    .pop_vld  (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  dma_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (rx_push),
    .push_dat (wdata_q),
    .pop_vld  (rd_ready),
    .head_dat (rd_data),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    tc_flag_d = tc_flag_q;
    tc_seen_d = tc_seen_q;
    busy_d    = busy_q;
    aborted_d = aborted_q;
    wdata_d   = wdata_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    drive     = 1'b0;
    done_c    = 1'b0;
    can_serve = (dir_q == DIR_DEV2MEM) ? !tx_empty : !rx_full;
    strobe_n  = (dir_q == DIR_MEM2DEV) ? io_write_n : io_read_n;
    drq       = (state_q == ST_REQ) && can_serve;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d     = direction;
          tc_seen_d = 1'b0;
          tc_flag_d = 1'b0;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_RELEASE;
        end else if (drq && !dma_acknowledge_n && !strobe_n) begin
          // A strobe may be a single cycle, so the handshake cycle already samples data and TC.
          state_d = ST_XFER;
          if (!terminal_count_n) tc_flag_d = 1'b1;
          if (dir_q == DIR_MEM2DEV) wdata_d = data_bus_in;
          else                      drive   = 1'b1;
        end
      end
      ST_XFER: begin
        if (abort)             aborted_d = 1'b1;
        if (!terminal_count_n) tc_flag_d = 1'b1;
        if (strobe_n) begin
          if (!(aborted_q || abort)) begin
            if (dir_q == DIR_DEV2MEM) tx_pop  = 1'b1;
            else                      rx_push = 1'b1;
          end
          state_d = ST_RELEASE;
        end else if (dir_q == DIR_MEM2DEV) begin
          wdata_d = data_bus_in;
        end else if (!dma_acknowledge_n) begin
          drive = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (abort) aborted_d = 1'b1;
        if (dma_acknowledge_n) begin
          if (aborted_q || abort) begin
            done_c    = 1'b1;
            busy_d    = 1'b0;
            tc_seen_d = 1'b0;
            state_d   = ST_IDLE;
          end else if (tc_flag_q) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_FINISH: begin
        done_c    = 1'b1;
        tc_seen_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_DEV2MEM;
      tc_flag_q <= 1'b0;
      tc_seen_q <= 1'b0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tc_flag_q <= tc_flag_d;
      tc_seen_q <= tc_seen_d;
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      wdata_q   <= wdata_d;
    end
  end

  assign dma_request         = drq;
  assign data_bus_out_enable = drive;
  assign data_bus_out        = drive ? tx_head : 8'h00;
  assign busy                = busy_q;
  assign done                = done_c;
  assign tc_seen             = tc_seen_q;
  assign wr_ready            = !tx_full;
  assign rd_valid            = !rx_empty;

endmodule

// File: doc/dma_requester.md
DMA_REQUESTER -- requirements
Module: DMA_REQUESTER

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, byte depth of each FIFO, power of two, 4..64.
REQ-002 SHALL have ports in this order:
  clock  in  1  single clock; all logic on its rising edge.
  reset  in  1  synchronous, active-low reset.
  dma_request  out  1  DRQ to the chipset DMA channel.
  dma_acknowledge_n  in  1  DACK from the chipset, active-low.
  io_read_n  in  1  bus IOR strobe, active-low.
  io_write_n  in  1  bus IOW strobe, active-low.
  terminal_count_n  in  1  TC from the chipset, active-low.
  data_bus_in  in  8  bus data sampled on memory-to-device cycles.
  data_bus_out  out  8  data driven on device-to-memory cycles.
  data_bus_out_enable  out  1  high while data_bus_out is valid for the chipset mux.
  start  in  1  one-cycle pulse that arms a transfer block.
  direction  in  1  0 = device-to-memory (IOR); 1 = memory-to-device (IOW); sampled at start.
  abort  in  1  one-cycle pulse that cancels the block.
  busy  out  1  high from start to completion.
  done  out  1  one-cycle pulse at completion.
  tc_seen  out  1  high if the block ended on TC; cleared by start.
  wr_data  in  8  local byte to push into the TX FIFO.
  wr_valid  in  1  local push request.
  wr_ready  out  1  TX FIFO not full.
  rd_data  out  8  RX FIFO head byte.
  rd_valid  out  1  RX FIFO not empty.
  rd_ready  in  1  local pop request.

Function
REQ-003 SHALL implement states IDLE, REQ, XFER, RELEASE and FINISH.
REQ-004 IDLE: on start, SHALL latch direction, clear tc_seen, set busy and go to REQ; start while busy SHALL be ignored.
REQ-005 REQ: SHALL assert dma_request while the selected FIFO can serve a byte (TX not empty if direction=0; RX not full if direction=1), and otherwise deassert it and stay in REQ.
REQ-006 REQ to XFER SHALL occur when dma_acknowledge_n=0 together with the direction's strobe low (io_read_n for 0, io_write_n for 1) and dma_request is high; dma_request SHALL drop in that same cycle (single-transfer mode).
REQ-007 XFER, direction 0: data_bus_out SHALL equal the TX head and data_bus_out_enable=1 combinationally while dma_acknowledge_n=0 and io_read_n=0.
REQ-008 XFER, direction 0: on the first cycle io_read_n is high again, the TX head SHALL be popped.
REQ-009 XFER, direction 1: data_bus_in SHALL be registered every cycle io_write_n=0; the last sampled value SHALL be pushed into the RX FIFO on the cycle io_write_n returns high.
REQ-010 Any cycle in XFER with terminal_count_n=0 SHALL set an internal TC flag.
REQ-011 After the pop or push, SHALL go to RELEASE and wait for dma_acknowledge_n=1, then go to FINISH if the TC flag is set, else to REQ.
REQ-012 FINISH: SHALL pulse done for one cycle, set tc_seen, clear busy and return to IDLE.
REQ-013 abort SHALL, in any state, drop dma_request in the next cycle.
REQ-014 abort in XFER SHALL let the strobe complete without pop or push, and the FSM SHALL then go through RELEASE to IDLE with a done pulse and tc_seen=0.
REQ-015 DACK or a strobe in IDLE, REQ without dma_request, or RELEASE SHALL be ignored: no drive, no FIFO change.
REQ-016 Local push and DMA pop on the same TX FIFO cycle SHALL both succeed; the same holds for DMA push and local pop on the RX FIFO.
REQ-017 Counts SHALL be log2(FIFO_DEPTH)+1 bits and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 A push when full or a pop when empty SHALL be dropped with no state change.
REQ-019 The FIFOs SHALL have zero read latency: rd_data is valid whenever rd_valid=1.

Reset
REQ-020 While reset=0 at a clock edge, SHALL force IDLE with both FIFOs empty and the TC flag clear.
REQ-021 Outputs during reset SHALL be dma_request=0, data_bus_out_enable=0, data_bus_out=8'h00, busy=0, done=0, tc_seen=0, wr_ready=1, rd_valid=0.
REQ-022 Reset mid-transfer SHALL abandon the byte with no pop or push.

Structure
REQ-023 A shared package SHALL hold the state enum and the direction constants DIR_DEV2MEM=0 and DIR_MEM2DEV=1.
REQ-024 A single sub-module DMA_FIFO (synchronous byte FIFO, parameter FIFO_DEPTH) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-025 Push 8'hA5 and 8'h3C, start with direction=0, run two DACK+IOR cycles with TC on the second -> data_bus_out shows A5 then 3C, done pulses, tc_seen=1, wr_ready=1.
REQ-026 Start with direction=1, run a DACK+IOW cycle with data_bus_in=8'h5A and TC -> rd_valid=1, rd_data=5A, done pulses.
REQ-027 With FIFO_DEPTH=4, direction=1 and no local pops, four IOW cycles without TC -> after the fourth, dma_request stays 0; one rd_ready pop -> dma_request returns to 1.
REQ-028 Pulse DACK+IOR while idle -> data_bus_out_enable stays 0 and TX count is unchanged.
REQ-029 Abort during IOR low -> no pop occurs, done pulses after DACK releases, tc_seen=0.
REQ-030 Assert reset=0 during XFER -> the next cycle shows every REQ-021 output value and both FIFOs empty.
